// File: rtl/pwm_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : pwm_output_stage
// Description : Turns the SPI control registers (output enables, PWM mode
//               selects, duty cycle) into 16 registered output pins. Each pin
//               is low, static high, or driven by a shared 8-bit PWM
//               waveform generated from a clock prescaler and period counter.
// Option      : PWM_DUTY_SHADOW_EN - when defined, the duty cycle is captured
//               into a shadow register at each period boundary so that duty
//               changes never cut a PWM period short.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_output_stage #(
    parameter int CLK_DIV = 3000,
    parameter int DIV_W   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]       CNT_LAST = 8'hFF;

    logic [DIV_W-1:0] prescaler_q, prescaler_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [15:0]      out_q, out_d;
    logic             period_start_q, period_start_d;

    logic             tick;
    logic             wrap;
    logic [7:0]       duty_act;
    logic             pwm_sig;
    logic [15:0]      en_out;
    logic [15:0]      en_pwm;

    // Prescaler, period counter and period-boundary detection.
    always_comb begin
        tick           = (prescaler_q == DIV_LAST);
        prescaler_d    = tick ? '0 : prescaler_q + 1'b1;
        pwm_cnt_d      = pwm_cnt_q + {7'd0, tick};
        wrap           = tick && (pwm_cnt_q == CNT_LAST);
        period_start_d = wrap;
    end

`ifdef PWM_DUTY_SHADOW_EN
    logic [7:0] duty_act_q, duty_act_d;

    // Shadow duty: reload only when the counter wraps into a new period.
    always_comb begin
        duty_act_d = wrap ? pwm_duty_cycle : duty_act_q;
    end

    // Shadow duty register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act_q <= 8'h00;
        end else begin
            duty_act_q <= duty_act_d;
        end
    end

    // The compare uses the value being loaded so the new period's first
    // output cycle already reflects the new duty.
    assign duty_act = duty_act_d;
`else
    assign duty_act = pwm_duty_cycle;
`endif

    // PWM compare and per-bit output select. The compare looks at the count
    // the counter is moving to, so a registered output bit lines up with the
    // pwm_cnt value held in the same cycle, and a register change coincident
    // with a tick sees the updated count.
    always_comb begin
        en_out = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
        if (duty_act == 8'hFF) begin
            pwm_sig = 1'b1;
        end else if (duty_act == 8'h00) begin
            pwm_sig = 1'b0;
        end else begin
            pwm_sig = (pwm_cnt_d < duty_act);
        end
        out_d = en_out & (~en_pwm | {16{pwm_sig}});
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q    <= '0;
            pwm_cnt_q      <= 8'h00;
            out_q          <= 16'h0000;
            period_start_q <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            pwm_cnt_q      <= pwm_cnt_d;
            out_q          <= out_d;
            period_start_q <= period_start_d;
        end
    end

    assign out          = out_q;
    assign period_start = period_start_q;

endmodule
`default_nettype wire
